par_serial_tx: RTL and testbench



---
 rtl/par_serial_pkg.sv | 13 +
 rtl/sync_fifo.sv | 73 +++++++
 rtl/par_serial_tx.sv | 127 ++++++++++++
 tb/tb_par_serial_tx.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/par_serial_pkg.sv
// Shared types and constants for the serial byte transmitter.
package par_serial_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] COMMA_DEFAULT = 8'hBC;
  localparam logic [BYTE_W-1:0] IDLE_DEFAULT  = 8'h7C;

  typedef enum logic {
    SYNC,
    RUN
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small register-based FIFO with registered count/full/empty flags.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             full_reg;
  logic             empty_reg;

  // Storage has no reset; validity is tracked by the pointers and count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (wr_en && (wr_ptr_reg == AW'(gi))) begin
          mem_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    if (wr_en && !rd_en) begin
      count_next = count_reg + CW'(1);
    end else if (rd_en && !wr_en) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
      full_reg  <= (count_next == CW'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  // Head is read combinationally so a pop can load it on the same edge.
  assign rd_data = mem_reg[rd_ptr_reg];
  assign count   = count_reg;
  assign full    = full_reg;
  assign empty   = empty_reg;

endmodule

// File: rtl/par_serial_tx.sv
// Byte-to-serial transmitter: MSB-first line with COMMA alignment after
// reset, IDLE fill when the input FIFO is empty.
module par_serial_tx
  import par_serial_pkg::*;
#(
  parameter int                FIFO_DEPTH = 4,
  parameter int                SYNC_BYTES = 4,
  parameter logic [BYTE_W-1:0] COMMA      = COMMA_DEFAULT,
  parameter logic [BYTE_W-1:0] IDLE       = IDLE_DEFAULT,
  localparam int               CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              valid_in,
  output logic              data_out,
  output logic              frame_start,
  output logic              sending_data,
  output logic              fifo_full,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow
);

  localparam int BIT_W  = $clog2(BYTE_W);
  localparam int SYNC_W = $clog2(SYNC_BYTES + 1);

  tx_state_e         state_reg;
  tx_state_e         state_next;
  logic [SYNC_W-1:0] sync_cnt_reg;
  logic [SYNC_W-1:0] sync_cnt_next;
  logic [BIT_W-1:0]  bit_cnt_reg;
  logic [BIT_W-1:0]  bit_cnt_next;
  logic [BYTE_W-1:0] shreg_reg;
  logic [BYTE_W-1:0] shreg_next;
  logic              after_reset_reg;
  logic              data_out_reg;
  logic              frame_start_reg;
  logic              frame_start_next;
  logic              sending_data_reg;
  logic              sending_data_next;
  logic              overflow_reg;

  logic              boundary;
  logic              pop;
  logic              wr_en;
  logic [BYTE_W-1:0] fifo_rd_data;
  logic              fifo_full_w;
  logic              fifo_empty_w;

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .srst    (reset),
    .wr_en   (wr_en),
    .wr_data (data_in),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full_w),
    .empty   (fifo_empty_w)
  );

  // The first edge after reset opens a slot even though bit_cnt is 7.
  assign boundary = after_reset_reg || (bit_cnt_reg == '0);
  assign pop      = boundary && (state_reg == RUN) && !fifo_empty_w;
  assign wr_en    = valid_in && (!fifo_full_w || pop);

  always_comb begin
    state_next        = state_reg;
    sync_cnt_next     = sync_cnt_reg;
    shreg_next        = shreg_reg;
    bit_cnt_next      = bit_cnt_reg - BIT_W'(1);
    frame_start_next  = 1'b0;
    sending_data_next = sending_data_reg;
    if (boundary) begin
      bit_cnt_next     = BIT_W'(BYTE_W - 1);
      frame_start_next = 1'b1;
      if (state_reg == SYNC) begin
        shreg_next        = COMMA;
        sending_data_next = 1'b0;
        sync_cnt_next     = sync_cnt_reg + SYNC_W'(1);
        if (sync_cnt_reg == SYNC_W'(SYNC_BYTES - 1)) begin
          state_next = RUN;
        end
      end else if (pop) begin
        shreg_next        = fifo_rd_data;
        sending_data_next = 1'b1;
      end else begin
        shreg_next        = IDLE;
        sending_data_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= SYNC;
      sync_cnt_reg     <= '0;
      bit_cnt_reg      <= BIT_W'(BYTE_W - 1);
      shreg_reg        <= '0;
      after_reset_reg  <= 1'b1;
      data_out_reg     <= 1'b0;
      frame_start_reg  <= 1'b0;
      sending_data_reg <= 1'b0;
      overflow_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      sync_cnt_reg     <= sync_cnt_next;
      bit_cnt_reg      <= bit_cnt_next;
      shreg_reg        <= shreg_next;
      after_reset_reg  <= 1'b0;
      data_out_reg     <= shreg_next[bit_cnt_next];
      frame_start_reg  <= frame_start_next;
      sending_data_reg <= sending_data_next;
      overflow_reg     <= overflow_reg || (valid_in && !wr_en);
    end
  end

  assign data_out     = data_out_reg;
  assign frame_start  = frame_start_reg;
  assign sending_data = sending_data_reg;
  assign fifo_full    = fifo_full_w;
  assign overflow     = overflow_reg;

endmodule

// File: tb/tb_par_serial_tx.sv
// Self-checking bench for par_serial_tx: scenario tasks plus a byte monitor
// that checks every data byte on the line against an expected-byte queue.
module tb_par_serial_tx;

  localparam logic [7:0] COMMA_B = 8'hBC;
  localparam logic [7:0] IDLE_B  = 8'h7C;

  typedef struct {
    logic [7:0] b;
    logic       sd;
    int         cyc;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       data_out;
  logic       frame_start;
  logic       sending_data;
  logic       fifo_full;
  logic [2:0] fifo_count;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int cyc = -1;

  logic [7:0] exp_q[$];
  obs_t       obs_q[$];

  par_serial_tx #(
    .FIFO_DEPTH (4),
    .SYNC_BYTES (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .data_out     (data_out),
    .frame_start  (frame_start),
    .sending_data (sending_data),
    .fifo_full    (fifo_full),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Cycle k is the period after the k-th edge following reset release.
  always @(posedge clk) begin
    if (reset) cyc <= -1;
    else       cyc <= cyc + 1;
  end

  // Byte monitor: assembles line bytes, checks data bytes against exp_q.
  initial begin : monitor
    int         nbits;
    logic       active;
    logic [7:0] cur;
    logic       sd;
    int         start;
    nbits = 0; active = 1'b0; cur = 8'h00; sd = 1'b0; start = 0;
    forever begin
      @(negedge clk);
      if (cyc < 0) begin
        active = 1'b0;
        nbits  = 0;
        obs_q.delete();
      end else if (frame_start === 1'b1) begin
        if (active) begin
          checks++;
          if (nbits != 8) begin
            errors++;
            $display("FAIL byte_length: got %0d bits, want 8 (cycle %0d)", nbits, cyc);
          end
        end
        active = 1'b1;
        nbits  = 1;
        cur    = {7'b0, data_out};
        sd     = sending_data;
        start  = cyc;
      end else if (active) begin
        checks++;
        if (nbits >= 8) begin
          errors++;
          $display("FAIL frame_start_missing: got 0 at cycle %0d, want 1", cyc);
          active = 1'b0;
        end else begin
          if (sending_data !== sd) begin
            errors++;
            $display("FAIL sending_data_steady: got %b want %b (cycle %0d)", sending_data, sd, cyc);
          end
          cur = {cur[6:0], data_out};
          nbits++;
          if (nbits == 8) begin
            obs_q.push_back('{b: cur, sd: sd, cyc: start});
            if (sd) begin
              checks++;
              if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_data: got %02h at cycle %0d, want none", cur, start);
              end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (cur !== e) begin
                  errors++;
                  $display("FAIL data_byte: got %02h want %02h (cycle %0d)", cur, e, start);
                end
              end
            end
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc != n && guard < 500);
    if (cyc != n) begin
      checks++;
      errors++;
      $display("FAIL wait_cycle: got cycle %0d want %0d", cyc, n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({data_out, frame_start, sending_data, fifo_full, fifo_count, overflow} !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: got do=%b fs=%b sd=%b full=%b cnt=%0d ovf=%b want all 0",
               data_out, frame_start, sending_data, fifo_full, fifo_count, overflow);
    end
    reset = 1'b0;
    wait_cyc(0);
    checks++;
    if (frame_start !== 1'b1 || data_out !== 1'b1 || sending_data !== 1'b0) begin
      errors++;
      $display("FAIL first_slot: got fs=%b do=%b sd=%b want 1 1 0", frame_start, data_out, sending_data);
    end
    wait_cyc(1);
    checks++;
    if (frame_start !== 1'b0 || data_out !== 1'b0) begin
      errors++;
      $display("FAIL second_bit: got fs=%b do=%b want 0 0", frame_start, data_out);
    end
  endtask

  task automatic test_sync_idle();
    logic [7:0] e;
    wait_cyc(56);
    checks++;
    if (obs_q.size() < 7) begin
      errors++;
      $display("FAIL sync_idle_count: got %0d bytes want 7", obs_q.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        e = (i < 4) ? COMMA_B : IDLE_B;
        checks++;
        if (obs_q[i].b !== e || obs_q[i].sd !== 1'b0 || obs_q[i].cyc != 8 * i) begin
          errors++;
          $display("FAIL sync_idle_byte%0d: got %02h sd=%b cyc=%0d want %02h sd=0 cyc=%0d",
                   i, obs_q[i].b, obs_q[i].sd, obs_q[i].cyc, e, 8 * i);
        end
      end
    end
  endtask

  task automatic test_sync_write();
    do_reset();
    wait_cyc(3);
    valid_in = 1'b1; data_in = 8'hA5; exp_q.push_back(8'hA5);
    wait_cyc(4);
    valid_in = 1'b0;
    checks++;
    if (fifo_count !== 3'd1) begin
      errors++; $display("FAIL sync_write_cnt4: got %0d want 1", fifo_count);
    end
    wait_cyc(31);
    checks++;
    if (fifo_count !== 3'd1 || sending_data !== 1'b0) begin
      errors++; $display("FAIL sync_write_cnt31: got cnt=%0d sd=%b want 1 0", fifo_count, sending_data);
    end
    wait_cyc(32);
    checks++;
    if (fifo_count !== 3'd0 || sending_data !== 1'b1 || frame_start !== 1'b1) begin
      errors++;
      $display("FAIL sync_write_pop: got cnt=%0d sd=%b fs=%b want 0 1 1", fifo_count, sending_data, frame_start);
    end
    wait_cyc(48);
    checks++;
    if (obs_q.size() < 6 || obs_q[4].b !== 8'hA5 || obs_q[4].cyc != 32 || obs_q[5].b !== IDLE_B) begin
      errors++; $display("FAIL sync_write_line: got %0d bytes, want A5 at 32 then IDLE", obs_q.size());
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sync_write_drain: got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_boundary_write();
    do_reset();
    wait_cyc(39);
    valid_in = 1'b1; data_in = 8'h3C; exp_q.push_back(8'h3C);
    wait_cyc(40);
    valid_in = 1'b0;
    checks++;
    if (frame_start !== 1'b1 || sending_data !== 1'b0 || fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL bnd_write_slot: got fs=%b sd=%b cnt=%0d want 1 0 1", frame_start, sending_data, fifo_count);
    end
    wait_cyc(48);
    checks++;
    if (sending_data !== 1'b1 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL bnd_write_next: got sd=%b cnt=%0d want 1 0", sending_data, fifo_count);
    end
    wait_cyc(56);
    checks++;
    if (obs_q.size() < 7 || obs_q[5].b !== IDLE_B || obs_q[6].b !== 8'h3C || exp_q.size() != 0) begin
      errors++; $display("FAIL bnd_write_line: got %0d bytes, %0d pending, want IDLE then 3C", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wait_cyc(3 + i);
      valid_in = 1'b1; data_in = 8'(8'h11 * (i + 1)); exp_q.push_back(8'(8'h11 * (i + 1)));
    end
    wait_cyc(7);
    valid_in = 1'b0;
    checks++;
    if (fifo_count !== 3'd4 || fifo_full !== 1'b1) begin
      errors++; $display("FAIL full_fill: got cnt=%0d full=%b want 4 1", fifo_count, fifo_full);
    end
    wait_cyc(31);
    valid_in = 1'b1; data_in = 8'h55; exp_q.push_back(8'h55);
    wait_cyc(32);
    valid_in = 1'b0;
    checks++;
    if (fifo_count !== 3'd4 || fifo_full !== 1'b1 || overflow !== 1'b0 || sending_data !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_same_edge: got cnt=%0d full=%b ovf=%b sd=%b want 4 1 0 1",
               fifo_count, fifo_full, overflow, sending_data);
    end
    wait_cyc(72);
    checks++;
    if (exp_q.size() != 0 || overflow !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL full_pop_drain: got pending=%0d ovf=%b cnt=%0d want 0 0 0", exp_q.size(), overflow, fifo_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    wait_cyc(40);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) wait_cyc(40 + i);
      if (i == 4) begin
        checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
          errors++; $display("FAIL ovf_before: got cnt=%0d ovf=%b want 4 0", fifo_count, overflow);
        end
      end
      valid_in = 1'b1; data_in = 8'(i + 1);
      if (i < 4) exp_q.push_back(8'(i + 1));
    end
    wait_cyc(46);
    valid_in = 1'b0;
    checks++;
    if (fifo_count !== 3'd4 || fifo_full !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after: got cnt=%0d full=%b ovf=%b want 4 1 1", fifo_count, fifo_full, overflow);
    end
    wait_cyc(80);
    checks++;
    if (obs_q.size() < 10 || obs_q[6].b !== 8'h01 || obs_q[9].b !== 8'h04 || exp_q.size() != 0) begin
      errors++; $display("FAIL ovf_line: got %0d bytes, %0d pending, want 01..04", obs_q.size(), exp_q.size());
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got %b want 1", overflow);
    end
  endtask

  task automatic test_reset_mid_byte();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wait_cyc(3 + i);
      valid_in = 1'b1; data_in = 8'(8'hAA + 8'(i * 17));
    end
    wait_cyc(6);
    valid_in = 1'b0;
    wait_cyc(35);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({data_out, frame_start, sending_data, fifo_full, fifo_count, overflow} !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_values: got do=%b fs=%b sd=%b full=%b cnt=%0d ovf=%b want all 0",
               data_out, frame_start, sending_data, fifo_full, fifo_count, overflow);
    end
    reset = 1'b0;
    wait_cyc(56);
    checks++;
    if (obs_q.size() < 7) begin
      errors++; $display("FAIL mid_reset_count: got %0d bytes want 7", obs_q.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (obs_q[i].b !== ((i < 4) ? COMMA_B : IDLE_B) || obs_q[i].sd !== 1'b0) begin
          errors++;
          $display("FAIL mid_reset_byte%0d: got %02h sd=%b want %02h sd=0",
                   i, obs_q[i].b, obs_q[i].sd, (i < 4) ? COMMA_B : IDLE_B);
        end
      end
    end
    checks++;
    if (fifo_count !== 3'd0) begin
      errors++; $display("FAIL mid_reset_fifo: got cnt=%0d want 0", fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_sync_idle();
    test_sync_write();
    test_boundary_write();
    test_full_pop();
    test_overflow();
    test_reset_mid_byte();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
